// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: shared instruction/data memory port between the multi-cycle
// controller (master) and the unified memory (slave). mem_ack completes a
// request that mem_req holds asserted.
interface mc_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic mem_sel;
    logic mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_sel,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_sel,
        output mem_ack
    );
endinterface

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS controller, one instruction at a time through
// FETCH/DECODE/EXEC/MEM/WB. Strobes are combinational from state, opcode and
// funct; a low reset forces every output to 0 in the same cycle.
// Optional feature: define MC_CTRL_PERF_EN to add the instret counter/port.
module mc_ctrl
`ifdef MC_CTRL_PERF_EN
#(
    parameter int INSTRET_W = 32
)
`endif
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    mc_ctrl_if.master   mem,
    output logic        ir_we,
    output logic        pc_we,
    output logic        rf_we,
    output logic [2:0]  npc_op,
    output logic [3:0]  alu_op,
    output logic [2:0]  dm_op,
    output logic [1:0]  wr_sel,
    output logic [1:0]  rfwd_sel,
    output logic        b_sel,
    output logic        imm_ext_op,
    output logic        illegal,
    output logic [2:0]  state
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [INSTRET_W-1:0] instret
`endif
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_JR    = 6'b001000;

    state_e      state_r;
    state_e      next_s;
    logic        dec_ok_s;
    logic        dec_jmp_s;
    logic        dec_jal_s;
    logic        dec_beq_s;
    logic        dec_ld_s;
    logic        dec_st_s;
    logic [2:0]  dec_npc_s;
    logic [3:0]  dec_alu_s;
    logic        dec_bsel_s;
    logic        dec_ext_s;
    logic [2:0]  dec_dm_s;
    logic [1:0]  dec_wr_s;
    logic [1:0]  dec_rfwd_s;

    // Instruction decode: class flags and per-instruction control values.
    always_comb begin
        dec_ok_s   = 1'b1;
        dec_jmp_s  = 1'b0;
        dec_jal_s  = 1'b0;
        dec_beq_s  = 1'b0;
        dec_ld_s   = 1'b0;
        dec_st_s   = 1'b0;
        dec_npc_s  = 3'd0;
        dec_alu_s  = 4'd0;
        dec_bsel_s = 1'b0;
        dec_ext_s  = 1'b0;
        dec_dm_s   = 3'd0;
        dec_wr_s   = 2'd0;
        dec_rfwd_s = 2'd0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD: begin dec_alu_s = 4'd0; dec_wr_s = 2'd1; end
                    FN_SUB: begin dec_alu_s = 4'd1; dec_wr_s = 2'd1; end
                    FN_SLT: begin dec_alu_s = 4'd3; dec_wr_s = 2'd1; end
                    FN_SLL: begin dec_alu_s = 4'd5; dec_wr_s = 2'd1; end
                    FN_JR:  begin dec_jmp_s = 1'b1; dec_npc_s = 3'd4; end
                    default: dec_ok_s = 1'b0;
                endcase
            end
            OP_ORI: begin dec_alu_s = 4'd2; dec_bsel_s = 1'b1; end
            OP_LUI: begin dec_alu_s = 4'd4; dec_bsel_s = 1'b1; end
            OP_LW:  begin dec_ld_s = 1'b1; dec_bsel_s = 1'b1; dec_ext_s = 1'b1; dec_dm_s = 3'd0; dec_rfwd_s = 2'd1; end
            OP_LB:  begin dec_ld_s = 1'b1; dec_bsel_s = 1'b1; dec_ext_s = 1'b1; dec_dm_s = 3'd1; dec_rfwd_s = 2'd1; end
            OP_LBU: begin dec_ld_s = 1'b1; dec_bsel_s = 1'b1; dec_ext_s = 1'b1; dec_dm_s = 3'd5; dec_rfwd_s = 2'd1; end
            OP_SW:  begin dec_st_s = 1'b1; dec_bsel_s = 1'b1; dec_ext_s = 1'b1; dec_dm_s = 3'd0; end
            OP_SB:  begin dec_st_s = 1'b1; dec_bsel_s = 1'b1; dec_ext_s = 1'b1; dec_dm_s = 3'd1; end
            OP_BEQ: begin dec_beq_s = 1'b1; dec_alu_s = 4'd1; dec_ext_s = 1'b1; dec_npc_s = 3'd1; end
            OP_J:   begin dec_jmp_s = 1'b1; dec_npc_s = 3'd2; end
            OP_JAL: begin dec_jal_s = 1'b1; dec_npc_s = 3'd3; dec_wr_s = 2'd2; dec_rfwd_s = 2'd2; end
            default: dec_ok_s = 1'b0;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state selection; memory states wait indefinitely for mem_ack.
    always_comb begin
        next_s = state_r;
        case (state_r)
            S_FETCH:  next_s = mem.mem_ack ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (!dec_ok_s || dec_jmp_s) next_s = S_FETCH;
                else if (dec_jal_s)         next_s = S_WB;
                else                        next_s = S_EXEC;
            end
            S_EXEC: begin
                if (dec_beq_s)                  next_s = S_FETCH;
                else if (dec_ld_s || dec_st_s)  next_s = S_MEM;
                else                            next_s = S_WB;
            end
            S_MEM: begin
                if (!mem.mem_ack)   next_s = S_MEM;
                else if (dec_st_s)  next_s = S_FETCH;
                else                next_s = S_WB;
            end
            S_WB:    next_s = S_FETCH;
            default: next_s = S_FETCH;
        endcase
    end

    // Datapath strobes per state; a low reset forces everything to 0.
    always_comb begin
        mem.mem_req = 1'b0;
        mem.mem_we  = 1'b0;
        mem.mem_sel = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        rf_we       = 1'b0;
        npc_op      = 3'd0;
        alu_op      = 4'd0;
        dm_op       = 3'd0;
        wr_sel      = 2'd0;
        rfwd_sel    = 2'd0;
        b_sel       = 1'b0;
        imm_ext_op  = 1'b0;
        illegal     = 1'b0;
        state       = 3'd0;
        if (reset) begin
            state = state_r;
            if (state_r == S_EXEC || state_r == S_MEM || state_r == S_WB) begin
                alu_op     = dec_alu_s;
                b_sel      = dec_bsel_s;
                imm_ext_op = dec_ext_s;
                dm_op      = dec_dm_s;
            end else begin
                alu_op     = 4'd0;
            end
            case (state_r)
                S_FETCH: begin
                    mem.mem_req = 1'b1;
                    ir_we       = mem.mem_ack;
                    pc_we       = mem.mem_ack;
                    npc_op      = 3'd0;
                end
                S_DECODE: begin
                    if (!dec_ok_s) begin
                        illegal = 1'b1;
                    end else if (dec_jmp_s || dec_jal_s) begin
                        pc_we  = 1'b1;
                        npc_op = dec_npc_s;
                    end else begin
                        pc_we  = 1'b0;
                    end
                end
                S_EXEC: begin
                    if (dec_beq_s) begin
                        pc_we  = zero;
                        npc_op = dec_npc_s;
                    end else begin
                        pc_we  = 1'b0;
                    end
                end
                S_MEM: begin
                    mem.mem_req = 1'b1;
                    mem.mem_sel = 1'b1;
                    mem.mem_we  = dec_st_s;
                end
                S_WB: begin
                    rf_we    = 1'b1;
                    wr_sel   = dec_wr_s;
                    rfwd_sel = dec_rfwd_s;
                end
                default: state = 3'd0;
            endcase
        end else begin
            state = 3'd0;
        end
    end

`ifdef MC_CTRL_PERF_EN
    logic [INSTRET_W-1:0] instret_r;
    logic                 retire_s;

    // An instruction retires on the edge that returns the FSM to FETCH.
    always_comb begin
        case (state_r)
            S_DECODE: retire_s = dec_ok_s && dec_jmp_s;
            S_EXEC:   retire_s = dec_beq_s;
            S_MEM:    retire_s = dec_st_s && mem.mem_ack;
            S_WB:     retire_s = 1'b1;
            default:  retire_s = 1'b0;
        endcase
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (!reset) begin
            instret_r <= {INSTRET_W{1'b0}};
        end else if (retire_s) begin
            instret_r <= instret_r + {{(INSTRET_W-1){1'b0}}, 1'b1};
        end else begin
            instret_r <= instret_r;
        end
    end

    // Counter is visible only while out of reset.
    always_comb begin
        if (reset) begin
            instret = instret_r;
        end else begin
            instret = {INSTRET_W{1'b0}};
        end
    end
`endif
endmodule
